led_fade_sequencer: RTL and testbench

Shares one fade-ramp engine between several LED channels. Each channel requests a fade; a round-robin scheduler grants one channel at a time. The granted channel's 4-bit duty cycle is stepped 0 → DUTY_MAX → hold → 0 under an internal step timer. Sits between the animation control logic and the per-channel PWM generators, and drives their `duty_cycle` inputs.

---
 rtl/led_fade_sequencer.sv | 167 ++++++++++++++++
 tb/tb_led_fade_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_sequencer.sv
// Shared fade-ramp engine: round-robin grants one LED channel at a time and ramps its duty 0 -> DUTY_MAX -> 0.
// Optional peak hold is enabled by defining LED_FADE_HOLD_EN; otherwise the ramp turns around at DUTY_MAX.
module led_fade_sequencer #(
  parameter int N_CH     = 4,
  parameter int DUTY_MAX = 10,
  parameter int STEP_T   = 20,
  parameter int HOLD_T   = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     req,
  input  logic                abort,
  output logic [4*N_CH-1:0]   duty_bus,
  output logic [N_CH-1:0]     grant,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam int LW = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (N_CH < 2 || N_CH > 8 || DUTY_MAX < 1 || DUTY_MAX > 15 ||
      STEP_T < 1 || STEP_T > 255 || HOLD_T < 1 || HOLD_T > 255) begin : g_param_check
    $error("led_fade_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, RISE, HOLD, FALL, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      duty_q, duty_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [LW-1:0]   last_q, last_d;
  logic            aborted_q, aborted_d;

  logic            found;
  logic [LW-1:0]   pick, cand;
  logic [N_CH-1:0] clr;
  logic            step_end;
  logic            in_fade;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      pending_q <= '0;
      last_q    <= LW'(N_CH - 1);
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      aborted_q <= aborted_d;
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = LW'((int'(last_q) + k) % N_CH);
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign step_end = (cnt_q == 8'(STEP_T - 1));
  assign in_fade  = (state_q == RISE) || (state_q == HOLD) || (state_q == FALL);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aborted_d = aborted_q;
    clr       = '0;

    if (abort && in_fade) begin
      state_d   = DONE;
      duty_d    = '0;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_d = RISE;
            grant_d = N_CH'(1) << pick;
            clr     = N_CH'(1) << pick;
            last_d  = pick;
            duty_d  = '0;
            cnt_d   = '0;
          end
        end
        RISE: begin
          if (step_end) begin
            cnt_d  = '0;
            duty_d = duty_q + 4'd1;
            if (duty_q + 4'd1 == 4'(DUTY_MAX)) begin
`ifdef LED_FADE_HOLD_EN
              state_d = HOLD;
`else
              state_d = FALL;
`endif
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`ifdef LED_FADE_HOLD_EN
        HOLD: begin
          if (cnt_q == 8'(HOLD_T - 1)) begin
            state_d = FALL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`endif
        FALL: begin
          if (step_end) begin
            cnt_d  = '0;
            duty_d = duty_q - 4'd1;
            if (duty_q == 4'd1) state_d = DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_d   = IDLE;
          grant_d   = '0;
          aborted_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end

    // A request on the same edge as the grant re-arms the bit.
    pending_d = (pending_q & ~clr) | req;
  end

  always_comb begin
    duty_bus = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_q[i]) duty_bus[4*i +: 4] = duty_q;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign aborted = aborted_q;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Self-checking bench for led_fade_sequencer: elapsed-time fade model plus directed and random stimulus.
module tb_led_fade_sequencer;

  localparam int N_CH = 4;
  localparam int DM   = 3;
  localparam int ST   = 2;
  localparam int HT   = 3;
`ifdef LED_FADE_HOLD_EN
  localparam int HOLD_CYC = HT;
`else
  localparam int HOLD_CYC = 0;
`endif
  localparam int RAMP = DM * ST;
  localparam int FADE = 2 * RAMP + HOLD_CYC;

  logic              clk;
  logic              rst_n;
  logic [N_CH-1:0]   req;
  logic              abort;
  logic [4*N_CH-1:0] duty_bus;
  logic [N_CH-1:0]   grant;
  logic              busy;
  logic              done;
  logic              aborted;

  led_fade_sequencer #(.N_CH(N_CH), .DUTY_MAX(DM), .STEP_T(ST), .HOLD_T(HT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .abort(abort),
    .duty_bus(duty_bus), .grant(grant), .busy(busy), .done(done), .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fade progress is the number of edges since the grant.
  int              m_act;
  int              m_t;
  bit              m_done;
  bit              m_abt;
  logic [N_CH-1:0] m_pend;
  int              m_last;

  function automatic int duty_at(input int t);
    if (t < RAMP) return t / ST;
    if (t < RAMP + HOLD_CYC) return DM;
    return DM - (t - RAMP - HOLD_CYC) / ST;
  endfunction

  task automatic model_reset();
    m_act = -1; m_t = 0; m_done = 0; m_abt = 0; m_pend = '0; m_last = N_CH - 1;
  endtask

  task automatic model_step(input logic [N_CH-1:0] r, input logic a);
    logic [N_CH-1:0] c;
    c = '0;
    if (m_act < 0) begin
      if (m_pend != 0) begin
        for (int k = 1; k <= N_CH; k++) begin
          int ch;
          ch = (m_last + k) % N_CH;
          if (m_act < 0 && m_pend[ch]) m_act = ch;
        end
        m_last = m_act; m_t = 0; m_done = 0; m_abt = 0;
        c[m_act] = 1'b1;
      end
    end else if (m_done) begin
      m_act = -1; m_done = 0; m_abt = 0;
    end else if (a) begin
      m_done = 1; m_abt = 1;
    end else begin
      m_t++;
      if (m_t == FADE) m_done = 1;
    end
    m_pend = (m_pend & ~c) | r;
  endtask

  task automatic compare_outputs();
    logic [4*N_CH-1:0] eb;
    logic [N_CH-1:0]   eg;
    eb = '0;
    eg = '0;
    if (m_act >= 0) begin
      eg[m_act] = 1'b1;
      if (!m_done) eb[4*m_act +: 4] = 4'(duty_at(m_t));
    end
    check("grant", grant, eg);
    check("duty_bus", duty_bus, eb);
    check("busy", busy, (m_act >= 0));
    check("done", done, m_done);
    check("aborted", aborted, (m_done && m_abt));
  endtask

  // Event log decoded from DUT outputs for the directed scenarios.
  int prev_ch, idle_run, n_done, n_abt;
  int q_chan[$];
  int q_gap[$];

  task automatic clear_log();
    prev_ch = -1; idle_run = 0; n_done = 0; n_abt = 0;
    q_chan.delete(); q_gap.delete();
  endtask

  task automatic sample_log();
    int ch;
    ch = -1;
    for (int i = 0; i < N_CH; i++) if (grant[i]) ch = (ch < 0) ? i : -2;
    if (ch >= 0 && prev_ch < 0) begin
      q_chan.push_back(ch);
      q_gap.push_back(idle_run);
    end
    idle_run = (ch < 0) ? idle_run + 1 : 0;
    prev_ch  = ch;
    if (done) n_done++;
    if (done && aborted) n_abt++;
  endtask

  // Called at a falling edge: check this cycle, then drive inputs for the next rising edge.
  task automatic tick(input logic [N_CH-1:0] r, input logic a);
    compare_outputs();
    sample_log();
    req   = r;
    abort = a;
    if (rst_n) model_step(r, a);
    else       model_reset();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; abort = 1'b0;
    model_reset();
    @(negedge clk);
    tick('0, 1'b0);
    rst_n = 1'b1;
    clear_log();
  endtask

  int exp_seq[$];
  int got_seq[$];
  int done_idx, gcyc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef LED_FADE_HOLD_EN
    exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 2, 2, 1, 1, 0};
`else
    exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0};
`endif
    rst_n = 1'b0; req = '0; abort = 1'b0;
    model_reset();
    clear_log();
    @(negedge clk);
    check("rst_duty", duty_bus, 0);
    check("rst_grant", grant, 0);
    check("rst_flags", {busy, done, aborted}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fade on channel 0.
    tick(4'b0001, 1'b0);
    tick('0, 1'b0);
    check("first_grant", grant, 4'b0001);
    done_idx = -1; gcyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < exp_seq.size()) got_seq.push_back(int'(duty_bus[3:0]));
      if (done && done_idx < 0) done_idx = i;
      if (grant != 0) gcyc++;
      tick('0, 1'b0);
    end
    for (int i = 0; i < exp_seq.size(); i++)
      check($sformatf("fade_duty[%0d]", i), got_seq[i], exp_seq[i]);
    check("done_index", done_idx, exp_seq.size() - 1);
    check("grant_cycles", gcyc, exp_seq.size());

    // Round-robin over all four channels.
    do_reset();
    tick(4'b1111, 1'b0);
    repeat (4 * (FADE + 2) + 8) tick('0, 1'b0);
    check("rr_grants", q_chan.size(), 4);
    for (int i = 0; i < 4 && i < q_chan.size(); i++) check($sformatf("rr_order[%0d]", i), q_chan[i], i);
    for (int i = 1; i < 4 && i < q_gap.size(); i++) check($sformatf("rr_gap[%0d]", i), q_gap[i], 1);
    check("rr_done_count", n_done, 4);
    check("rr_abort_count", n_abt, 0);

    // Re-queue of the active channel during its fall.
    do_reset();
    tick(4'b0100, 1'b0);
    repeat (10) tick('0, 1'b0);
    tick(4'b0100, 1'b0);
    repeat (2 * (FADE + 2) + 5) tick('0, 1'b0);
    check("rq_grants", q_chan.size(), 2);
    for (int i = 0; i < 2 && i < q_chan.size(); i++) check($sformatf("rq_chan[%0d]", i), q_chan[i], 2);
    if (q_gap.size() > 1) check("rq_gap", q_gap[1], 1);

    // Abort while channel 0 sits at duty 2 in RISE; channel 2 waits.
    do_reset();
    tick(4'b0101, 1'b0);
    repeat (5) tick('0, 1'b0);
    check("ab_pre_duty", duty_bus, 16'h0002);
    tick('0, 1'b1);
    check("ab_duty", duty_bus, 0);
    check("ab_done", {done, aborted}, 2'b11);
    repeat (FADE + 10) tick('0, 1'b0);
    check("ab_grants", q_chan.size(), 2);
    if (q_chan.size() > 1) check("ab_next_chan", q_chan[1], 2);
    check("ab_abort_count", n_abt, 1);

    // Asynchronous reset in the middle of a fade.
    do_reset();
    tick(4'b0111, 1'b0);
    repeat (8) tick('0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_duty", duty_bus, 0);
    check("mr_grant", grant, 0);
    check("mr_flags", {busy, done, aborted}, 0);
    model_reset();
    @(negedge clk);
    tick('0, 1'b0);
    rst_n = 1'b1;
    clear_log();
    repeat (20) tick('0, 1'b0);
    check("mr_no_grant", q_chan.size(), 0);
    check("mr_no_done", n_done, 0);

    // Random traffic with sparse requests, aborts and one reset.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      logic [N_CH-1:0] r;
      logic            a;
      r = ($urandom_range(0, 9) == 0) ? N_CH'($urandom) : '0;
      a = ($urandom_range(0, 39) == 0);
      if (k == 800) begin
        rst_n = 1'b0;
        model_reset();
        #1;
      end
      if (k == 803) rst_n = 1'b1;
      tick(r, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
